// File: rtl/star_noc_pkg.sv
// Shared flit format for the star NoC: field widths, flit layout and accessors.
// Used by both the hub switch and the leaf route logic.
package star_noc_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int FLIT_W = 2*ADDR_W + DATA_W;

    localparam int DATA_LSB = 0;
    localparam int DEST_LSB = DATA_W;
    localparam int SRC_LSB  = DATA_W + ADDR_W;

    // src sits in the MSBs so the packed struct matches the wire layout
    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } flit_t;

    function automatic logic [ADDR_W-1:0] flit_dest(input flit_t f);
        return f.dest;
    endfunction

    function automatic logic [ADDR_W-1:0] flit_src(input flit_t f);
        return f.src;
    endfunction

    function automatic logic [DATA_W-1:0] flit_data(input flit_t f);
        return f.data;
    endfunction

    function automatic flit_t make_flit(input logic [ADDR_W-1:0] src,
                                        input logic [ADDR_W-1:0] dest,
                                        input logic [DATA_W-1:0] data);
        flit_t f;
        f.src  = src;
        f.dest = dest;
        f.data = data;
        return f;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// Latency: grant is combinational; pointer advances past the winner on an enabled grant.
// Backpressure: en=0 suppresses the grant and freezes the pointer.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt_ptr;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        found   = 1'b0;
        nxt_ptr = ptr;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx[PW-1:0]]) begin
                found               = 1'b1;
                gnt[idx[PW-1:0]]    = en;
                nxt_ptr             = (idx == N-1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= nxt_ptr;
        end
    end

endmodule

// File: rtl/star_hub_switch.sv
// Star NoC hub: buffers one flit per uplink, routes by dest, round-robin per downlink.
// Latency: capture at edge t, out_valid visible for consumption at edge t+2; 1 flit/cycle/output.
// Backpressure: out_ready low holds the output register; in_ready is low while a buffered flit waits.
module star_hub_switch
    import star_noc_pkg::*;
#(
    parameter int NUM_LEAVES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LEAVES-1:0]        in_valid,
    output logic [NUM_LEAVES-1:0]        in_ready,
    input  logic [NUM_LEAVES*FLIT_W-1:0] in_flit,
    output logic [NUM_LEAVES-1:0]        out_valid,
    input  logic [NUM_LEAVES-1:0]        out_ready,
    output logic [NUM_LEAVES*FLIT_W-1:0] out_flit,
    output logic [7:0]                   drop_count
);

    logic [NUM_LEAVES-1:0] ibuf_v;
    flit_t                 ibuf_flit [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] ibuf_bad;
    logic [NUM_LEAVES-1:0] ibuf_leave;

    logic [NUM_LEAVES-1:0] obuf_v;
    flit_t                 obuf_flit [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] out_load;

    // req/gnt are indexed [output][input]
    logic [NUM_LEAVES-1:0] req [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] gnt [NUM_LEAVES];
    flit_t                 win_flit [NUM_LEAVES];

    logic [8:0]            drop_sum;
    logic [7:0]            drop_next;

    always_comb begin
        for (int i = 0; i < NUM_LEAVES; i++) begin
            ibuf_bad[i] = ibuf_v[i] && (int'(flit_dest(ibuf_flit[i])) >= NUM_LEAVES);
        end
        for (int j = 0; j < NUM_LEAVES; j++) begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                req[j][i] = ibuf_v[i] && (int'(flit_dest(ibuf_flit[i])) == j);
            end
        end
        out_load = ~obuf_v | out_ready;
    end

    for (genvar j = 0; j < NUM_LEAVES; j++) begin : g_arb
        rr_arbiter #(.N(NUM_LEAVES)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (req[j]),
            .en  (out_load[j]),
            .gnt (gnt[j])
        );
    end

    always_comb begin
        ibuf_leave = ibuf_bad;
        for (int j = 0; j < NUM_LEAVES; j++) begin
            win_flit[j] = '0;
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (gnt[j][i]) begin
                    ibuf_leave[i] = 1'b1;
                    win_flit[j]   = ibuf_flit[i];
                end
            end
        end
    end

    // Ready depends on this cycle's grants so a buffer can drain and refill back to back
    always_comb begin
        in_ready = rst ? '0 : (~ibuf_v | ibuf_leave);
    end

    always_comb begin
        drop_sum = {1'b0, drop_count};
        for (int i = 0; i < NUM_LEAVES; i++) begin
            drop_sum = drop_sum + 9'(ibuf_bad[i]);
        end
        drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_v     <= '0;
            obuf_v     <= '0;
            drop_count <= '0;
            for (int i = 0; i < NUM_LEAVES; i++) begin
                ibuf_flit[i] <= '0;
                obuf_flit[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    ibuf_v[i]    <= 1'b1;
                    ibuf_flit[i] <= in_flit[i*FLIT_W +: FLIT_W];
                end else if (ibuf_leave[i]) begin
                    ibuf_v[i] <= 1'b0;
                end
            end
            for (int j = 0; j < NUM_LEAVES; j++) begin
                if (out_load[j]) begin
                    obuf_v[j] <= |gnt[j];
                    if (|gnt[j]) begin
                        obuf_flit[j] <= win_flit[j];
                    end
                end
            end
            drop_count <= drop_next;
        end
    end

    always_comb begin
        out_valid = obuf_v;
        out_flit  = '0;
        for (int j = 0; j < NUM_LEAVES; j++) begin
            out_flit[j*FLIT_W +: FLIT_W] = obuf_flit[j];
        end
    end

endmodule

// File: tb/tb_star_hub_switch.sv
// Bench for star_hub_switch: per-(src,dest) ordered scoreboard fed by uplink handshakes,
// drained by downlink handshakes, plus directed latency/ordering/backpressure/drop scenarios.
module tb_star_hub_switch;
    import star_noc_pkg::*;

    localparam int N  = 4;
    localparam int FW = FLIT_W;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*FW-1:0] in_flit;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*FW-1:0] out_flit;
    logic [7:0]      drop_count;

    always #5 clk = ~clk;

    star_hub_switch #(.NUM_LEAVES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_flit    (in_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_flit   (out_flit),
        .drop_count (drop_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard state, owned by the monitor
    flit_t    sbq [$];
    int       ord2 [$];
    int       deliv [N];
    int       exp_drops;
    logic [N-1:0] stalled;
    flit_t    held [N];
    flit_t    mf;
    flit_t    mo;
    int       hit;

    initial begin
        exp_drops = 0;
        stalled   = '0;
        for (int j = 0; j < N; j++) begin
            deliv[j] = 0;
            held[j]  = '0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                exp_drops = 0;
                stalled   = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (in_valid[i] && in_ready[i]) begin
                        mf = in_flit[i*FW +: FW];
                        if (int'(flit_dest(mf)) < N) sbq.push_back(mf);
                        else if (exp_drops < 255) exp_drops++;
                    end
                end
                for (int j = 0; j < N; j++) begin
                    mo = out_flit[j*FW +: FW];
                    if (stalled[j]) begin
                        chk("hold_valid", 64'(out_valid[j]), 64'(1));
                        chk("hold_flit", 64'(mo), 64'(held[j]));
                    end
                    if (out_valid[j] && out_ready[j]) begin
                        hit = -1;
                        for (int k = 0; k < sbq.size(); k++) begin
                            if (hit < 0 && flit_src(sbq[k]) == flit_src(mo) &&
                                int'(flit_dest(sbq[k])) == j) hit = k;
                        end
                        chk("sb_match", 64'(hit >= 0), 64'(1));
                        if (hit >= 0) begin
                            chk("out_flit", 64'(mo), 64'(sbq[hit]));
                            sbq.delete(hit);
                        end
                        deliv[j]++;
                        if (j == 2) ord2.push_back(int'(flit_src(mo)));
                    end
                    stalled[j] = out_valid[j] && !out_ready[j];
                    held[j]    = mo;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input int d, input logic [31:0] dat);
        in_valid[i] = 1'b1;
        in_flit[i*FW +: FW] = make_flit(ADDR_W'(i), ADDR_W'(d), dat);
    endtask

    task automatic send(input int i, input int d, input logic [31:0] dat);
        int k;
        k = 0;
        set_in(i, d, dat);
        @(negedge clk);
        while (!in_ready[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("send_timeout", 64'(k), 64'(0));
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    // one flit with no contention must be consumable exactly two edges after capture
    task automatic single_latency(input int s, input int d, input logic [31:0] dat);
        set_in(s, d, dat);
        @(negedge clk);
        chk("lat_in_ready", 64'(in_ready[s]), 64'(1));
        tick();
        in_valid[s] = 1'b0;
        @(negedge clk);
        chk("lat_early_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_valid", 64'(out_valid), 64'(1) << d);
        chk("lat_flit", 64'(out_flit[d*FW +: FW]), 64'(make_flit(ADDR_W'(s), ADDR_W'(d), dat)));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int exp_ord [3] = '{0, 1, 3};
    int base [N];

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_flit   = '0;
        out_ready = '1;

        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_flit", 64'(out_flit), 64'(0));
        chk("rst_drop", 64'(drop_count), 64'(0));
        chk("rst_in_ready_after", 64'(in_ready), 64'hF);
        tick();

        single_latency(0, 2, 32'hDEADBEEF);
        repeat (2) tick();

        // contention on output 2, twice to show the pointer wraps back to leaf 0
        do_reset();
        for (int r = 0; r < 2; r++) begin
            ord2.delete();
            set_in(0, 2, 32'h1000 + 32'(r));
            set_in(1, 2, 32'h1100 + 32'(r));
            set_in(3, 2, 32'h1300 + 32'(r));
            @(negedge clk);
            chk("cont_rdy0", 64'(in_ready), 64'hF);
            tick();
            in_valid = '0;
            @(negedge clk);
            chk("cont_rdy1", 64'(in_ready), 64'b0101);
            @(negedge clk);
            chk("cont_rdy2", 64'(in_ready), 64'b0111);
            @(negedge clk);
            chk("cont_rdy3", 64'(in_ready), 64'hF);
            repeat (3) @(negedge clk);
            chk("cont_count", 64'(ord2.size()), 64'(3));
            for (int k = 0; k < ord2.size() && k < 3; k++) begin
                chk("cont_order", 64'(ord2[k]), 64'(exp_ord[k]));
            end
            tick();
        end

        // backpressure on output 1 while leaf 2 streams three flits
        out_ready[1] = 1'b0;
        base[1] = deliv[1];
        fork
            begin
                send(2, 1, 32'hA0A0_0001);
                send(2, 1, 32'hA0A0_0002);
                send(2, 1, 32'hA0A0_0003);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_in_ready", 64'(in_ready[2]), 64'(0));
                chk("bp_first_flit", 64'(out_flit[1*FW +: FW]),
                    64'(make_flit(ADDR_W'(2), ADDR_W'(1), 32'hA0A0_0001)));
                tick();
                out_ready[1] = 1'b1;
            end
        join
        repeat (4) tick();
        chk("bp_delivered", 64'(deliv[1] - base[1]), 64'(3));

        // invalid destination, then saturation
        send(1, 9, 32'h0000_0009);
        @(negedge clk);
        @(negedge clk);
        chk("drop_one", 64'(drop_count), 64'(1));
        chk("drop_no_out", 64'(out_valid), 64'(0));
        tick();
        for (int k = 0; k < 299; k++) send(1, 9, 32'(k));
        repeat (3) tick();
        chk("drop_sat", 64'(drop_count), 64'(255));
        chk("drop_model", 64'(drop_count), 64'(exp_drops));

        // permutation traffic at full rate
        for (int j = 0; j < N; j++) base[j] = deliv[j];
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < N; i++) set_in(i, (i + 1) % N, 32'(c * 16 + i));
            @(negedge clk);
            chk("tp_in_ready", 64'(in_ready), 64'hF);
            tick();
        end
        in_valid = '0;
        repeat (5) tick();
        for (int j = 0; j < N; j++) chk("tp_count", 64'(deliv[j] - base[j]), 64'(100));

        // reset while flits are buffered
        for (int i = 0; i < N; i++) set_in(i, 3, 32'h100 + 32'(i));
        tick();
        tick();
        in_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_drop", 64'(drop_count), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'hF);
        tick();
        single_latency(3, 0, 32'hCAFE_F00D);
        repeat (3) tick();

        chk("sb_empty", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
